// File: rtl/cam_cfg_pkg.sv
// rtl/cam_cfg_pkg.sv - shared types and constants for the camera config sequencer
//
// Purpose : state encoding, ROM marker defaults and ROM word field helpers
//           shared by cam_cfg_sequencer and its bench.
// Ports   : none (package).
package cam_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_DELAY  = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERROR  = 3'd7
   } cfg_state_t;

   localparam logic [15:0] END_MARK_DEF   = 16'hFFFF;
   localparam logic [15:0] DELAY_MARK_DEF = 16'hFFF0;

   // ROM word layout: {reg_addr, reg_data}
   localparam int ADDR_MSB = 15;
   localparam int DATA_MSB = 7;

   function automatic logic [7:0] word_reg_addr(input logic [15:0] w);
      return w[ADDR_MSB -: 8];
   endfunction

   function automatic logic [7:0] word_reg_data(input logic [15:0] w);
      return w[DATA_MSB -: 8];
   endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// rtl/cfg_delay_timer.sv - loadable down-counter with zero flag
//
// Purpose : counts down the wait inserted by a ROM delay marker.
// Ports   : i_sysclk/i_rstn clock and async active-low reset;
//           i_load/i_load_val load the count; i_dec decrements it
//           (saturating at 0); o_zero is high while the count is 0.
module cfg_delay_timer #(
   parameter int W = 22
) (
   input  logic         i_sysclk,
   input  logic         i_rstn,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] count;

   always_ff @(posedge i_sysclk or negedge i_rstn) begin
      if (!i_rstn) begin
         count <= '0;
      end else if (i_load) begin
         count <= i_load_val;
      end else if (i_dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign o_zero = (count == '0);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// rtl/cam_cfg_sequencer.sv - walks a camera register ROM into SCCB writes
//
// Purpose : on i_cfg_start, reads the register ROM entry by entry and issues
//           one SCCB write per entry, honouring delay and end markers and
//           retrying NACKed writes up to MAX_RETRY times.
// Ports   : i_sysclk, i_rstn (async active-low);
//           i_cfg_start            start request from system controller;
//           o_rom_addr, i_rom_data synchronous ROM (data one cycle after addr);
//           o_sccb_start/addr/data, i_sccb_ready/done/nack  SCCB master handshake;
//           o_cfg_busy/done/err    sequence status.
module cam_cfg_sequencer
   import cam_cfg_pkg::*;
#(
   parameter int          ROM_AW       = 8,
   parameter int          DELAY_CYCLES = 2_500_000,
   parameter int          MAX_RETRY    = 3,
   parameter logic [15:0] END_MARK     = END_MARK_DEF,
   parameter logic [15:0] DELAY_MARK   = DELAY_MARK_DEF
) (
   input  logic              i_sysclk,
   input  logic              i_rstn,
   input  logic              i_cfg_start,
   output logic [ROM_AW-1:0] o_rom_addr,
   input  logic [15:0]       i_rom_data,
   output logic              o_sccb_start,
   output logic [7:0]        o_sccb_addr,
   output logic [7:0]        o_sccb_data,
   input  logic              i_sccb_ready,
   input  logic              i_sccb_done,
   input  logic              i_sccb_nack,
   output logic              o_cfg_busy,
   output logic              o_cfg_done,
   output logic              o_cfg_err
);

   localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [DLY_W-1:0] DLY_LOAD  = DLY_W'(DELAY_CYCLES - 1);
   localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

   cfg_state_t        state_q, state_d;
   logic [RTY_W-1:0]  retry_cnt;
   logic              is_end, is_delay, at_last, dly_zero, advance, take_start;

   assign is_end     = (i_rom_data == END_MARK);
   assign is_delay   = !is_end && (i_rom_data == DELAY_MARK);
   assign at_last    = (o_rom_addr == {ROM_AW{1'b1}});
   assign take_start = i_cfg_start &&
                       (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
   // An entry is finished either by an ACKed write or an expired delay.
   assign advance    = ((state_q == ST_WAIT) && i_sccb_done && !i_sccb_nack) ||
                       ((state_q == ST_DELAY) && dly_zero);

   cfg_delay_timer #(.W(DLY_W)) u_delay (
      .i_sysclk   (i_sysclk),
      .i_rstn     (i_rstn),
      .i_load     ((state_q == ST_DECODE) && is_delay),
      .i_load_val (DLY_LOAD),
      .i_dec      (state_q == ST_DELAY),
      .o_zero     (dly_zero)
   );

   always_ff @(posedge i_sysclk or negedge i_rstn) begin
      if (!i_rstn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge i_sysclk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_rom_addr  <= '0;
         o_sccb_addr <= '0;
         o_sccb_data <= '0;
         retry_cnt   <= '0;
      end else begin
         if (take_start) begin
            o_rom_addr <= '0;
            retry_cnt  <= '0;
         end
         if ((state_q == ST_DECODE) && !is_end && !is_delay) begin
            o_sccb_addr <= word_reg_addr(i_rom_data);
            o_sccb_data <= word_reg_data(i_rom_data);
         end
         if ((state_q == ST_WAIT) && i_sccb_done) begin
            if (!i_sccb_nack)                retry_cnt <= '0;
            else if (retry_cnt < RETRY_MAX)  retry_cnt <= retry_cnt + 1'b1;
         end
         // The last ROM slot finishes the sequence instead of wrapping.
         if (advance && !at_last) o_rom_addr <= o_rom_addr + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: if (i_cfg_start) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            if (is_end)        state_d = ST_DONE;
            else if (is_delay) state_d = ST_DELAY;
            else               state_d = ST_ISSUE;
         end
         ST_ISSUE:  if (i_sccb_ready) state_d = ST_WAIT;
         ST_WAIT: begin
            if (i_sccb_done) begin
               if (!i_sccb_nack)              state_d = at_last ? ST_DONE : ST_FETCH;
               else if (retry_cnt < RETRY_MAX) state_d = ST_ISSUE;
               else                           state_d = ST_ERROR;
            end
         end
         ST_DELAY:  if (dly_zero) state_d = at_last ? ST_DONE : ST_FETCH;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_sccb_start = (state_q == ST_ISSUE) && i_sccb_ready;
      o_cfg_busy   = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
      o_cfg_done   = (state_q == ST_DONE);
      o_cfg_err    = (state_q == ST_ERROR);
   end

endmodule
